pair_iq_deadlock_reporter: RTL and testbench

- Receive-side consumer of the pair_iq deadlock monitor outputs (`block`, 9-bit `axis_block_info`).
- Qualifies a block condition that persists for `TIMEOUT` consecutive cycles and decodes which AXIS channels stalled, flagging malformed info fields.
- Emits one 32-bit report word per event over a valid/ready handshake and raises a sticky interrupt.
- Sits beside the pair_iq core; reports are drained by the control/debug logic.

---
 rtl/pair_iq_deadlock_reporter.sv | 181 ++++++++++++++++++
 tb/tb_pair_iq_deadlock_reporter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_iq_deadlock_reporter.sv
// Qualifies a persistent pair_iq deadlock block condition, decodes stalled AXIS channels
// and emits one report word per event. Optional gap timestamp: PAIR_IQ_DEADLOCK_DURATION_EN.
module pair_iq_deadlock_reporter #(
  parameter int TIMEOUT  = 16,
  parameter int NUM_AXIS = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    block,
  input  logic [3*NUM_AXIS-1:0]   axis_block_info,
  input  logic                    clear,
  output logic                    report_valid,
  input  logic                    report_ready,
  output logic [31:0]             report_data,
  output logic                    irq,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  // Handshake: a word transfers on a rising edge where report_valid && report_ready;
  // report_valid drops on that edge and report_data is frozen while report_valid is high.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [2*NUM_AXIS-1:0]   acc_q, acc_d;
  logic [7:0]              evt_q, evt_d;
  logic                    valid_q, valid_d;
  logic [31:0]             data_q, data_d;
  logic                    irq_q, irq_d;
  logic                    busy_q, busy_d;

  logic [NUM_AXIS-1:0]     dec_chan, dec_bad;
  logic [2*NUM_AXIS-1:0]   dec, fire_acc;
  logic [2:0]              field, pat;
  logic                    fire, handshake;
  logic [7:0]              evt_inc;
  logic [15:0]             gap_cap;

  // Field i names channel i only when exactly bit i is clear; any other nonzero value is malformed.
  always_comb begin
    dec_chan = '0;
    dec_bad  = '0;
    field    = '0;
    pat      = '0;
    for (int i = 0; i < NUM_AXIS; i++) begin
      field = axis_block_info[3*i +: 3];
      pat   = ~(3'b001 << i);
      if (field == pat) begin
        dec_chan[i] = 1'b1;
      end else if (field != 3'b000) begin
        dec_bad[i] = 1'b1;
      end
    end
    dec = {dec_bad, dec_chan};
  end

  assign handshake = valid_q && report_ready;
  assign evt_inc   = (evt_q == 8'hFF) ? evt_q : evt_q + 8'd1;

`ifdef PAIR_IQ_DEADLOCK_DURATION_EN
  logic [15:0] gap_q, gap_d;
  always_comb begin
    gap_d = gap_q;
    if (handshake) begin
      gap_d = 16'd0;
    end else if (gap_q != 16'hFFFF) begin
      gap_d = gap_q + 16'd1;
    end
  end
  assign gap_cap = gap_q;
`else
  assign gap_cap = 16'd0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    evt_d    = evt_q;
    valid_d  = valid_q;
    data_d   = data_q;
    irq_d    = irq_q;
    fire     = 1'b0;
    fire_acc = '0;
    case (state_q)
      IDLE: begin
        if (block) begin
          if (TIMEOUT == 1) begin
            fire     = 1'b1;
            fire_acc = dec;
          end else begin
            cnt_d   = 16'd1;
            acc_d   = dec;
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (block) begin
          if (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT)) begin
            fire     = 1'b1;
            fire_acc = acc_q | dec;
          end else begin
            cnt_d = cnt_q + 16'd1;
            acc_d = acc_q | dec;
          end
        end else begin
          cnt_d   = 16'd0;
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      REPORT: begin
        if (handshake) begin
          valid_d = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (clear) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The trigger cycle's own decode is already folded into fire_acc.
    if (fire) begin
      state_d = REPORT;
      cnt_d   = 16'd0;
      acc_d   = '0;
      evt_d   = evt_inc;
      valid_d = 1'b1;
      irq_d   = 1'b1;
      data_d  = {gap_cap, evt_inc, 2'b00, fire_acc};
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      acc_q   <= '0;
      evt_q   <= 8'd0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PAIR_IQ_DEADLOCK_DURATION_EN
      gap_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      evt_q   <= evt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
`ifdef PAIR_IQ_DEADLOCK_DURATION_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign report_valid = valid_q;
  assign report_data  = data_q;
  assign irq          = irq_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pair_iq_deadlock_reporter.sv
// Randomized bench for pair_iq_deadlock_reporter: a TIMEOUT=16 and a TIMEOUT=1 instance
// share stimulus and are scored every cycle against a run-length reference model.
module tb_pair_iq_deadlock_reporter;

  logic        clock;
  logic        reset;
  logic        block;
  logic [8:0]  info;
  logic        clear;
  logic        ready;

  logic        v16, v1, i16, i1, b16, b1;
  logic [31:0] d16, d1;
  logic [1:0]  s16, s1;

  int n_checks = 0;
  int n_errors = 0;

  pair_iq_deadlock_reporter #(.TIMEOUT(16), .NUM_AXIS(3)) dut16 (
    .clock(clock), .reset(reset), .block(block), .axis_block_info(info), .clear(clear),
    .report_valid(v16), .report_ready(ready), .report_data(d16), .irq(i16), .busy(b16),
    .dbg_state(s16)
  );

  pair_iq_deadlock_reporter #(.TIMEOUT(1), .NUM_AXIS(3)) dut1 (
    .clock(clock), .reset(reset), .block(block), .axis_block_info(info), .clear(clear),
    .report_valid(v1), .report_ready(ready), .report_data(d1), .irq(i1), .busy(b1),
    .dbg_state(s1)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: mode 0 = watching, 1 = report pending, 2 = acknowledged, awaiting clear
  int          m_t[2] = '{16, 1};
  int          m_mode[2];
  int          m_run[2];
  logic [5:0]  m_acc[2];
  logic        m_irq[2];
  int          m_evt[2];
  logic [31:0] m_word[2];
  int          m_gap[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] decode(input logic [8:0] v);
    logic [2:0] chan, bad, f, pat;
    chan = 3'b000;
    bad  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      f = v[3*i +: 3];
      pat = 3'b111;
      pat[i] = 1'b0;
      if (f == pat) chan[i] = 1'b1;
      else if (f != 3'b000) bad[i] = 1'b1;
    end
    return {bad, chan};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_run[k] = 0; m_acc[k] = '0; m_irq[k] = 1'b0;
      m_evt[k] = 0; m_word[k] = '0; m_gap[k] = 0;
    end
  endtask

  task automatic model_step();
    logic hs;
    logic [15:0] gap_field;
    for (int k = 0; k < 2; k++) begin
      hs = 1'b0;
`ifdef PAIR_IQ_DEADLOCK_DURATION_EN
      gap_field = 16'(m_gap[k]);
`else
      gap_field = 16'd0;
`endif
      if (m_mode[k] == 0) begin
        if (block) begin
          m_run[k]++;
          m_acc[k] = m_acc[k] | decode(info);
          if (m_run[k] == m_t[k]) begin
            if (m_evt[k] < 255) m_evt[k]++;
            m_word[k] = {gap_field, 8'(m_evt[k]), 2'b00, m_acc[k]};
            m_mode[k] = 1; m_irq[k] = 1'b1; m_run[k] = 0; m_acc[k] = '0;
          end
        end else begin
          m_run[k] = 0; m_acc[k] = '0;
        end
      end else if (m_mode[k] == 1) begin
        if (ready) begin m_mode[k] = 2; hs = 1'b1; end
      end else begin
        if (clear) begin m_mode[k] = 0; m_irq[k] = 1'b0; end
      end
      if (hs) m_gap[k] = 0;
      else if (m_gap[k] < 65535) m_gap[k]++;
    end
  endtask

  task automatic compare_all();
    logic ov, oi, ob;
    logic [31:0] od;
    logic [1:0] os, es;
    for (int k = 0; k < 2; k++) begin
      ov = (k == 0) ? v16 : v1;
      oi = (k == 0) ? i16 : i1;
      ob = (k == 0) ? b16 : b1;
      od = (k == 0) ? d16 : d1;
      os = (k == 0) ? s16 : s1;
      es = (m_mode[k] == 1) ? 2'd2 : (m_mode[k] == 2) ? 2'd3 : (m_run[k] > 0) ? 2'd1 : 2'd0;
      check($sformatf("valid[t%0d]", m_t[k]), 32'(ov), 32'(m_mode[k] == 1));
      check($sformatf("irq[t%0d]", m_t[k]), 32'(oi), 32'(m_irq[k]));
      check($sformatf("busy[t%0d]", m_t[k]), 32'(ob), 32'(m_mode[k] != 0 || m_run[k] > 0));
      check($sformatf("state[t%0d]", m_t[k]), 32'(os), 32'(es));
      if (m_mode[k] == 1) check($sformatf("data[t%0d]", m_t[k]), od, m_word[k]);
    end
  endtask

  // driver tasks
  task automatic drive(input logic b, input logic [8:0] inf, input logic rdy, input logic clr);
    block = b; info = inf; ready = rdy; clear = clr;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  function automatic logic [8:0] rand_info();
    logic [8:0] v;
    logic [2:0] pat;
    for (int i = 0; i < 3; i++) begin
      pat = 3'b111;
      pat[i] = 1'b0;
      case ($urandom_range(0, 3))
        0, 1:    v[3*i +: 3] = 3'b000;
        2:       v[3*i +: 3] = pat;
        default: v[3*i +: 3] = 3'($urandom_range(1, 7));
      endcase
    end
    return v;
  endfunction

  task automatic drain();
    drive(1'b0, 9'h000, 1'b1, 1'b0); cycle();
    drive(1'b0, 9'h000, 1'b0, 1'b1); cycle();
    drive(1'b0, 9'h000, 1'b0, 1'b0); cycle();
  endtask

  int rises;
  logic prev_v;
  logic [31:0] held;

  initial begin
    drive(1'b0, 9'h000, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_valid", 32'(v16), 32'd0);
    check("reset_data", d16, 32'd0);
    check("reset_irq", 32'(i16), 32'd0);
    check("reset_busy", 32'(b16), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // TIMEOUT=1: clear in HOLD with block still high re-reports on the next edge
    drive(1'b1, 9'h006, 1'b0, 1'b0); cycle();
    check("t1_first_evt", d1[15:0], 16'h0101);
    drive(1'b1, 9'h006, 1'b1, 1'b0); cycle();
    drive(1'b1, 9'h006, 1'b0, 1'b1); cycle();
    check("t1_clear_irq", 32'(i1), 32'd0);
    drive(1'b1, 9'h006, 1'b0, 1'b0); cycle();
    check("t1_second_valid", 32'(v1), 32'd1);
    check("t1_second_evt", 32'(d1[15:8]), 32'd2);
    drain();

    // TIMEOUT=16: sixteen edges of block with field0 = 3'b110
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 9'h006, 1'b0, 1'b0); cycle();
      if (c == 14) check("t16_not_early", 32'(v16), 32'd0);
    end
    check("t16_valid", 32'(v16), 32'd1);
    check("t16_irq", 32'(i16), 32'd1);
    check("t16_word", d16[15:0], 16'h0101);
    drain();
    drain();

    // glitch reject: 15 high, 1 low, 16 high gives exactly one report at the end
    rises = 0;
    for (int c = 0; c < 32; c++) begin
      prev_v = v16;
      drive(c != 15, 9'h000, 1'b0, 1'b0); cycle();
      if (!prev_v && v16) rises++;
      if (c == 30) check("glitch_not_early", 32'(v16), 32'd0);
    end
    check("glitch_reports", 32'(rises), 32'd1);
    drain();
    drain();

    // OR accumulation: field1 malformed throughout, field2 names channel 2 for one cycle
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, (c == 7) ? 9'b011_111_000 : 9'b000_111_000, 1'b0, 1'b0); cycle();
    end
    check("accum_bits", 32'(d16[7:0]), 32'h14);

    // backpressure: word and valid hold for 10 cycles of input churn, then transfer
    held = d16;
    for (int c = 0; c < 10; c++) begin
      drive(1'($urandom_range(0, 1)), rand_info(), 1'b0, 1'b1); cycle();
    end
    check("bp_stable", d16, held);
    drive(1'b1, rand_info(), 1'b1, 1'b0); cycle();
    check("bp_hold_state", 32'(s16), 32'd3);
    check("bp_irq_sticky", 32'(i16), 32'd1);
    drain();
    drain();

    // asynchronous reset mid-REPORT clears outputs without a clock edge
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, rand_info(), 1'b0, 1'b0); cycle();
    end
    #2;
    reset = 1'b0;
    #1;
    check("areset_valid", 32'(v16), 32'd0);
    check("areset_data", d16, 32'd0);
    check("areset_irq", 32'(i16), 32'd0);
    check("areset_busy", 32'(b16), 32'd0);
    check("areset_valid1", 32'(v1), 32'd0);
    model_reset();
    drive(1'b0, 9'h000, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // randomized traffic: long block bursts, random backpressure and clears
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 19) != 0, rand_info(),
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
